// File: rtl/c3aibadapt_cmn_clkgate_ctrl_pkg.sv
// Shared state encoding and counter widths for the adapter clock-gate controller.
package c3aibadapt_cmn_clkgate_ctrl_pkg;

    localparam int IDLE_W = 8;
    localparam int WAKE_W = 4;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } cg_state_e;

endpackage

// File: rtl/c3aibadapt_cmn_clkgate_idle_cnt.sv
// Clearable idle counter; pulses expire on the last idle cycle before gating
// and wraps back to zero so the counter reads 0 while the clock is gated.
module c3aibadapt_cmn_clkgate_idle_cnt
    import c3aibadapt_cmn_clkgate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expire
);

    localparam logic [IDLE_W-1:0] TC = IDLE_W'(IDLE_CYCLES - 1);

    logic [IDLE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire = 1'b0;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == TC) begin
            expire = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/c3aibadapt_cmn_clkgate_ctrl.sv
// Idle-detect clock-gate enable controller with request/ack wake-up.
// Define C3AIBADAPT_CLKGATE_STATS_EN to add the saturating gate_cnt statistic.
module c3aibadapt_cmn_clkgate_ctrl
    import c3aibadapt_cmn_clkgate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              wake_req,
    input  logic              force_on,
    output logic              gate_en,
    output logic              wake_ack,
    output logic              gated
`ifdef C3AIBADAPT_CLKGATE_STATS_EN
    ,
    output logic [STAT_W-1:0] gate_cnt
`endif
);

    localparam logic [WAKE_W-1:0] WAKE_TC = WAKE_W'(WAKE_CYCLES - 1);

    cg_state_e         state_q, state_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              gate_en_q, gate_en_d;
    logic              wake_ack_q, wake_ack_d;
    logic              gated_q, gated_d;
    logic              act, idle_clr, idle_expire;

    assign act      = busy | wake_req | force_on;
    assign idle_clr = (state_q != ST_RUN) | act;

    c3aibadapt_cmn_clkgate_idle_cnt #(
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_idle_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (idle_clr),
        .expire (idle_expire)
    );

    // Outputs are derived from next state so every output is a plain flop.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = '0;
        case (state_q)
            ST_RUN:   if (idle_expire) state_d = ST_GATED;
            ST_GATED: if (act)         state_d = ST_WAKE;
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_TC) state_d = ST_RUN;
                else                       wake_cnt_d = wake_cnt_q + 1'b1;
            end
            default:  state_d = ST_RUN;
        endcase
        gate_en_d  = (state_d != ST_GATED);
        gated_d    = (state_d == ST_GATED);
        wake_ack_d = (state_d == ST_RUN) & wake_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wake_cnt_q <= '0;
            gate_en_q  <= 1'b1;
            wake_ack_q <= 1'b0;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            gate_en_q  <= gate_en_d;
            wake_ack_q <= wake_ack_d;
            gated_q    <= gated_d;
        end
    end

    assign gate_en  = gate_en_q;
    assign wake_ack = wake_ack_q;
    assign gated    = gated_q;

`ifdef C3AIBADAPT_CLKGATE_STATS_EN
    logic [STAT_W-1:0] gate_cnt_q, gate_cnt_d;

    always_comb begin
        gate_cnt_d = gate_cnt_q;
        if ((state_q == ST_RUN) && (state_d == ST_GATED) && (gate_cnt_q != '1))
            gate_cnt_d = gate_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) gate_cnt_q <= '0;
        else     gate_cnt_q <= gate_cnt_d;
    end

    assign gate_cnt = gate_cnt_q;
`endif

endmodule

// File: tb/tb_c3aibadapt_cmn_clkgate_ctrl.sv
// Directed plus randomized bench for the clock-gate controller against a
// cycle-level behavioural model of the idle/wake rules.
module tb_c3aibadapt_cmn_clkgate_ctrl;

    localparam int IDLE = 16;
    localparam int WAKE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy = 1'b0, wake_req = 1'b0, force_on = 1'b0;
    logic gate_en, wake_ack, gated;
`ifdef C3AIBADAPT_CLKGATE_STATS_EN
    logic [15:0] gate_cnt;
`endif

    always #5 clk = ~clk;

    c3aibadapt_cmn_clkgate_ctrl #(
        .IDLE_CYCLES(IDLE),
        .WAKE_CYCLES(WAKE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .wake_req (wake_req),
        .force_on (force_on),
        .gate_en  (gate_en),
        .wake_ack (wake_ack),
        .gated    (gated)
`ifdef C3AIBADAPT_CLKGATE_STATS_EN
        ,
        .gate_cnt (gate_cnt)
`endif
    );

    // Behavioural model: "asleep" flag, idle run length, remaining wake cycles.
    bit m_asleep, m_waking, m_en, m_ack;
    int m_idle_run, m_wake_left, m_stat;
    int checks = 0, fails = 0;

    function automatic void model_edge(bit b, bit w, bit f, bit r);
        bit a;
        a = b | w | f;
        if (r) begin
            m_asleep = 0; m_waking = 0; m_idle_run = 0; m_ack = 0; m_stat = 0;
        end else if (m_asleep) begin
            m_ack = 0;
            if (a) begin
                m_asleep = 0; m_waking = 1; m_wake_left = WAKE;
            end
        end else if (m_waking) begin
            m_wake_left--;
            m_ack = 0;
            if (m_wake_left == 0) begin
                m_waking = 0; m_idle_run = 0; m_ack = w;
            end
        end else if (a) begin
            m_idle_run = 0; m_ack = w;
        end else begin
            m_idle_run++;
            m_ack = 0;
            if (m_idle_run >= IDLE) begin
                m_asleep = 1; m_idle_run = 0;
                if (m_stat < 16'hFFFF) m_stat++;
            end
        end
        m_en = !m_asleep;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit b, input bit w, input bit f, input bit r);
        busy = b; wake_req = w; force_on = f; rst = r;
        @(posedge clk);
        model_edge(b, w, f, r);
        #1;
        chk("gate_en", {15'd0, gate_en}, {15'd0, m_en});
        chk("wake_ack", {15'd0, wake_ack}, {15'd0, m_ack});
        chk("gated", {15'd0, gated}, {15'd0, m_asleep});
`ifdef C3AIBADAPT_CLKGATE_STATS_EN
        chk("gate_cnt", gate_cnt, m_stat[15:0]);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    bit rb, rw, rf, rr;

    initial begin
        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_gate_en", {15'd0, gate_en}, 16'd1);
        chk("rst_wake_ack", {15'd0, wake_ack}, 16'd0);

        // Idle gating: enable high through cycle 15, low from 16
        idle(IDLE - 1);
        chk("idle_pre_expire", {15'd0, gate_en}, 16'd1);
        step(0, 0, 0, 0);
        chk("idle_gated_en", {15'd0, gate_en}, 16'd0);
        chk("idle_gated_flag", {15'd0, gated}, 16'd1);

        // Wake from GATED with request/ack
        step(0, 1, 0, 0);
        chk("wake_en_t1", {15'd0, gate_en}, 16'd1);
        step(0, 1, 0, 0);
        chk("wake_noack_t2", {15'd0, wake_ack}, 16'd0);
        step(0, 1, 0, 0);
        chk("wake_ack_t3", {15'd0, wake_ack}, 16'd1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("wake_ack_drop", {15'd0, wake_ack}, 16'd0);

        // Activity restart: busy on the would-be expiry cycle
        step(0, 0, 0, 1);
        idle(IDLE - 1);
        step(1, 0, 0, 0);
        idle(IDLE - 1);
        chk("restart_still_on", {15'd0, gate_en}, 16'd1);
        step(0, 0, 0, 0);
        chk("restart_gated", {15'd0, gate_en}, 16'd0);

        // Force override from GATED: wakes without ack, holds enable
        step(0, 0, 1, 0);
        chk("force_en", {15'd0, gate_en}, 16'd1);
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 1, 0);
            chk("force_hold", {14'd0, wake_ack, gate_en}, 16'd1);
        end

        // Protocol violation: request dropped mid-WAKE, no ack issued
        idle(IDLE);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("viol_run_noack", {14'd0, wake_ack, gate_en}, 16'd1);

        // Reset mid-WAKE and mid-GATED
        idle(IDLE);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("rst_wake", {13'd0, gated, wake_ack, gate_en}, 16'd1);
        idle(IDLE);
        step(0, 0, 0, 1);
        chk("rst_gated", {13'd0, gated, wake_ack, gate_en}, 16'd1);

        // Randomized traffic with mostly well-behaved wake requests
        rw = 0; rf = 0;
        for (int i = 0; i < 4000; i++) begin
            rb = ($urandom_range(0, 11) == 0);
            if (!rw && $urandom_range(0, 29) == 0) rw = 1;
            else if (rw && m_ack && $urandom_range(0, 1) == 0) rw = 0;
            else if (rw && !m_ack && $urandom_range(0, 49) == 0) rw = 0;
            if ($urandom_range(0, 99) == 0) rf = !rf;
            rr = ($urandom_range(0, 299) == 0);
            step(rb, rw, rf, rr);
        end

`ifdef C3AIBADAPT_CLKGATE_STATS_EN
        // Three gate/wake cycles count to 3
        step(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            idle(IDLE);
            step(1, 0, 0, 0);
            idle(WAKE);
        end
        chk("stats_three", gate_cnt, 16'd3);
        // Preload near the limit, then gate twice: saturates
        @(negedge clk);
        force dut.gate_cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.gate_cnt_q;
        m_stat = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            idle(IDLE);
            step(1, 0, 0, 0);
            idle(WAKE);
        end
        chk("stats_sat", gate_cnt, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
